// File: rtl/fifo_ctrl_param_if.sv
// Handshake/data bundle between a producer/consumer and fifo_ctrl_param.
//
// Signals:
//   wr_en, rd_en, din    requests and write data (driven by the master)
//   dout                 registered read data
//   data_count           number of stored words, 0..2**ADDR_WIDTH
//   full, empty          count == DEPTH / count == 0
//   almost_full/empty    threshold flags decoded from data_count
//   wr_ack, wr_err       one-cycle pulse per accepted / rejected write
//   rd_ack, rd_err       one-cycle pulse per performed / rejected read
//   state                operation performed at the last edge
//
// Modports: master = producer/consumer side, slave = FIFO side.
interface fifo_ctrl_param_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic [ADDR_WIDTH:0]   data_count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [2:0]            state;

   modport master (
      output wr_en, rd_en, din,
      input  dout, data_count, full, empty, almost_full, almost_empty,
      input  wr_ack, wr_err, rd_ack, rd_err, state
   );

   modport slave (
      input  wr_en, rd_en, din,
      output dout, data_count, full, empty, almost_full, almost_empty,
      output wr_ack, wr_err, rd_ack, rd_err, state
   );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO: register-array storage, head/tail pointers,
// word count, threshold flags, per-request ack/err pulses and an exported
// operation-state register.
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-high reset (clears pointers, count, dout,
//         pulses and state; storage is left untouched)
//   bus   fifo_ctrl_param_if.slave -- requests, data, flags, pulses, state
//
// state | meaning
// ------+-------------------------------------------------------------
// 000   | INIT      after reset
// 001   | NO_OP     no request at the last edge
// 010   | WRITE     write accepted
// 011   | WR_ERROR  write rejected (full)
// 100   | READ      read performed
// 101   | RD_ERROR  read rejected (empty; a paired write may still land)
// 110   | RDWR      simultaneous read and write performed
// 111   | unused    next edge clears everything exactly like reset
module fifo_ctrl_param #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_LEVEL  = (2**ADDR_WIDTH) - 1,
   parameter int AEMPTY_LEVEL = 1
) (
   input logic          clk,
   input logic          rst,
   fifo_ctrl_param_if.slave bus
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LEVEL[ADDR_WIDTH:0];

   typedef enum logic [2:0] {
      ST_INIT     = 3'b000,
      ST_NO_OP    = 3'b001,
      ST_WRITE    = 3'b010,
      ST_WR_ERROR = 3'b011,
      ST_READ     = 3'b100,
      ST_RD_ERROR = 3'b101,
      ST_RDWR     = 3'b110,
      ST_UNUSED   = 3'b111
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] head_q, tail_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
   logic                  wr_ack_d, wr_err_d, rd_ack_d, rd_err_d;
   logic                  do_wr, do_rd, clr;
   logic                  is_full, is_empty;

   // Flags come from the registered count only, never from this cycle's requests.
   assign is_full  = (count_q == DEPTH_C);
   assign is_empty = (count_q == '0);

   always_comb begin
      state_d  = ST_NO_OP;
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      clr      = 1'b0;
      wr_ack_d = 1'b0;
      wr_err_d = 1'b0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
      if (state_q == ST_UNUSED) begin
         clr     = 1'b1;
         state_d = ST_INIT;
      end else begin
         case ({bus.wr_en, bus.rd_en})
            2'b10: begin
               if (!is_full) begin
                  do_wr    = 1'b1;
                  wr_ack_d = 1'b1;
                  state_d  = ST_WRITE;
               end else begin
                  wr_err_d = 1'b1;
                  state_d  = ST_WR_ERROR;
               end
            end
            2'b01: begin
               if (!is_empty) begin
                  do_rd    = 1'b1;
                  rd_ack_d = 1'b1;
                  state_d  = ST_READ;
               end else begin
                  rd_err_d = 1'b1;
                  state_d  = ST_RD_ERROR;
               end
            end
            2'b11: begin
               // At full head == tail: the read takes the old word through the
               // nonblocking update, and the write refills the freed slot.
               if (!is_empty) begin
                  do_wr    = 1'b1;
                  do_rd    = 1'b1;
                  wr_ack_d = 1'b1;
                  rd_ack_d = 1'b1;
                  state_d  = ST_RDWR;
               end else begin
                  // Empty: the write lands, the read is refused (no bypass of din).
                  do_wr    = 1'b1;
                  wr_ack_d = 1'b1;
                  rd_err_d = 1'b1;
                  state_d  = ST_RD_ERROR;
               end
            end
            default: state_d = ST_NO_OP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q  <= ST_INIT;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
         if (do_wr) begin
            tail_q <= tail_q + ADDR_WIDTH'(1);
         end
         if (do_rd) begin
            dout_q <= mem[head_q];
            head_q <= head_q + ADDR_WIDTH'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; do_wr is already low whenever clr is set.
   always_ff @(posedge clk) begin
      if (do_wr && !rst) begin
         mem[tail_q] <= bus.din;
      end
   end

   assign bus.dout         = dout_q;
   assign bus.data_count   = count_q;
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.almost_full  = (count_q >= AFULL_C);
   assign bus.almost_empty = (count_q <= AEMPTY_C);
   assign bus.wr_ack       = wr_ack_q;
   assign bus.wr_err       = wr_err_q;
   assign bus.rd_ack       = rd_ack_q;
   assign bus.rd_err       = rd_err_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
module tb_fifo_ctrl_param;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   fifo_ctrl_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_ctrl_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] sb [$];
   int            m_cnt;
   logic [DW-1:0] m_dout;
   logic [2:0]    m_state;
   logic          m_wack, m_werr, m_rack, m_rerr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the request, update the scoreboard model, compare after the edge.
   task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      @(negedge clk);
      rst       = r;
      bus.wr_en = w;
      bus.rd_en = rd;
      bus.din   = d;
      m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
      if (r) begin
         m_state = 3'b000;
         m_cnt   = 0;
         m_dout  = '0;
         sb.delete();
      end else if (!w && !rd) begin
         m_state = 3'b001;
      end else if (w && !rd) begin
         if (m_cnt < DEPTH) begin
            sb.push_back(d); m_cnt++; m_wack = 1'b1; m_state = 3'b010;
         end else begin
            m_werr = 1'b1; m_state = 3'b011;
         end
      end else if (!w && rd) begin
         if (m_cnt > 0) begin
            m_dout = sb.pop_front(); m_cnt--; m_rack = 1'b1; m_state = 3'b100;
         end else begin
            m_rerr = 1'b1; m_state = 3'b101;
         end
      end else begin
         if (m_cnt > 0) begin
            m_dout = sb.pop_front(); sb.push_back(d);
            m_wack = 1'b1; m_rack = 1'b1; m_state = 3'b110;
         end else begin
            sb.push_back(d); m_cnt++; m_wack = 1'b1; m_rerr = 1'b1; m_state = 3'b101;
         end
      end
      @(posedge clk);
      #1;
      chk("state",        32'(bus.state),        32'(m_state));
      chk("data_count",   32'(bus.data_count),   32'(m_cnt));
      chk("dout",         32'(bus.dout),         32'(m_dout));
      chk("wr_ack",       32'(bus.wr_ack),       32'(m_wack));
      chk("wr_err",       32'(bus.wr_err),       32'(m_werr));
      chk("rd_ack",       32'(bus.rd_ack),       32'(m_rack));
      chk("rd_err",       32'(bus.rd_err),       32'(m_rerr));
      chk("full",         32'(bus.full),         32'(m_cnt == DEPTH));
      chk("empty",        32'(bus.empty),        32'(m_cnt == 0));
      chk("almost_full",  32'(bus.almost_full),  32'(m_cnt >= DEPTH - 1));
      chk("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= 1));
   endtask

   initial begin
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
      m_cnt = 0; m_dout = '0; m_state = 3'b000;

      // Reset held two cycles with a write request pending.
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Fill 0x11..0x88, then overflow.
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i * 8'h11));
      step(1'b0, 1'b1, 1'b0, 8'h99);
      chk("overflow_count", 32'(bus.data_count), 32'd8);

      // Drain in order, then underflow with dout holding 0x88.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("underflow_dout", 32'(bus.dout), 32'h88);

      // Wrap-around: pointers pass 7->0.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hB0 + i));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

      // Simultaneous access at full: oldest word out, 0x99 into the freed slot.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      step(1'b0, 1'b1, 1'b1, 8'h99);
      chk("rdwr_full_dout", 32'(bus.dout), 32'hC0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("rdwr_last_word", 32'(bus.dout), 32'h99);

      // Simultaneous access at empty: write lands, read refused.
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Mixed back-to-back traffic.
      step(1'b0, 1'b1, 1'b0, 8'h01);
      step(1'b0, 1'b1, 1'b1, 8'h02);
      step(1'b0, 1'b1, 1'b1, 8'h03);
      step(1'b0, 1'b0, 1'b1, 8'h00);

      // Reset mid-operation together with a read, then a read on empty.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hD0 + i));
      step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_reset_rd_err", 32'(bus.rd_err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
